dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: the core load/store path (port C) and an external loader/debug port (port E).
- Fixed priority goes to C.
- A starvation counter guarantees E forward progress.
- A lock FSM lets E own the memory for multi-beat bursts.
- Drives the memory's addr/rdata2/wr_ctrl/rd_ctrl directly, and returns registered read data plus a response-valid to each requester.

Parameters:
WIDTH, 32, data/address width (from pipeline_hdrs).
MAX_WAIT, 4, cycles E may be refused before it preempts C (range 1..15).
CNT_W, 4, width of wait and performance counters.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
c_req  in  1  core request valid
c_addr  in  WIDTH  core address
c_wdata  in  WIDTH  core store data
c_wr_ctrl  in  3  000 sw, 001 sb, 010 sh, others = no write
c_rd_ctrl  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
c_gnt  out  1  core request accepted this cycle
c_stall  out  1  c_req & ~c_gnt, to pipeline hazard logic
c_rvalid  out  1  response for the accepted request, one cycle later
c_rdata  out  WIDTH  registered load data
e_req, e_addr, e_wdata, e_wr_ctrl, e_rd_ctrl, e_gnt, e_rvalid, e_rdata  as the core port, for E
e_lock  in  1  E requests to hold ownership after grant
m_addr  out  WIDTH  to memory addr
m_wdata  out  WIDTH  to memory rdata2
m_wr_ctrl  out  3  to memory wr_ctrl; 3'b011 when no write
m_rd_ctrl  out  3  to memory rd_ctrl
m_rdata  in  WIDTH  memory read data (combinational, same cycle)

Behaviour:
Grant generation:
- Combinational, single winner per cycle.
- c_gnt and e_gnt are never both 1.

Arbitration, state ARB:
- If wait_cnt == MAX_WAIT and e_req, E wins.
- Otherwise, if c_req, C wins.
- Otherwise, if e_req, E wins.

Lock FSM (states ARB, LOCK_E):
- ARB -> LOCK_E when e_gnt & e_lock.
- In LOCK_E, E wins whenever e_req; c_gnt = 0.
- LOCK_E -> ARB when e_lock = 0. That cycle still arbitrates as LOCK_E.

Memory outputs:
- Winner's addr/wdata/wr_ctrl/rd_ctrl are muxed to m_*.
- With no winner: m_wr_ctrl = 3'b011, m_rd_ctrl = 3'b010, m_addr = 0.
- Ungranted requesters must never cause a write.

Response path:
- On grant, m_rdata is captured into the winner's rdata register, and its rvalid is set the next cycle.
- Latency is exactly 1 cycle for both loads and stores; the store rdata value is don't-care.
- rvalid is a single-cycle pulse. The other port's rdata register holds its value.

Wait counter:
- Increments when e_req & ~e_gnt, saturating at MAX_WAIT.
- Clears on e_gnt or when e_req = 0.

Back-to-back operation:
- A requester granted in consecutive cycles gets consecutive rvalid pulses.
- Throughput is 1 transaction/cycle.

Reset (rst_n low, async):
- State = ARB, wait_cnt = 0.
- c_rvalid = e_rvalid = 0; c_rdata = e_rdata = 0.
- Grants are 0 while rst_n is low.
- Reset mid-burst drops the lock; no response is issued for the cycle in flight.

Requester obligation:
- Requests must hold addr/data/ctrl stable until granted.

Optional Feature:
DMEM_ARB_PERF_EN:
- Adds outputs perf_c_stall_cnt and perf_e_wait_cnt (CNT_W each, saturating).
- They count cycles of c_stall and of e_req & ~e_gnt.
- They are cleared by rst_n and by input perf_clr (sync).
- Without the macro, these ports and counters do not exist.

Decomposition:
Package dmem_arb_pkg holds:
- typedef enum arb_state_e {ARB, LOCK_E}
- localparams WR_SW = 3'b000, WR_SB = 3'b001, WR_SH = 3'b010, WR_NONE = 3'b011
- localparams RD_LB, RD_LH, RD_LW, RD_LBU, RD_LHU, and NO_OWNER
WIDTH comes from pipeline_hdrs.svh.

Sub-module dmem_arb_resp:
- Per-port registered rdata/rvalid stage.
- Instantiated twice.

Test Plan:
1. Only c_req, c_addr=0x10, c_rd_ctrl=010, memory holds 0xDEADBEEF at 0x10 -> c_gnt=1 same cycle, c_rvalid=1 next cycle with c_rdata=0xDEADBEEF; m_wr_ctrl=011.
2. c_req and e_req held high continuously, MAX_WAIT=4 -> C granted 4 cycles, E granted on cycle 5, C resumes cycle 6; c_stall=1 only in cycle 5.
3. E store e_addr=0x20, e_wdata=0x12345678, e_wr_ctrl=000, e_lock=1 for 3 beats while c_req=1 -> c_gnt=0 for all 3 beats plus the e_lock-drop cycle; readback by C at 0x20 returns 0x12345678.
4. Neither requesting -> m_wr_ctrl=011, no grants, no rvalid; memory contents unchanged (checked by readback).
5. Assert rst_n=0 asynchronously mid-burst in LOCK_E -> grants and rvalids drop immediately; after release, C granted on the first c_req.
6. With DMEM_ARB_PERF_EN, scenario 2 run for 10 cycles -> perf_c_stall_cnt=2, perf_e_wait_cnt=8; perf_clr zeroes both next cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and encodings for the data-memory arbiter.
//   DATA_W      default data/address width used by the pipeline
//   arb_state_e arbitration FSM states (ARB, LOCK_E)
//   WR_*        memory write-control encodings (WR_NONE = no write)
//   RD_*        memory read-control encodings
//   OWNER_*     which requester owns the memory in the current cycle
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int DATA_W = 32;

    typedef enum logic {
        ARB    = 1'b0,
        LOCK_E = 1'b1
    } arb_state_e;

    localparam logic [2:0] WR_SW   = 3'b000;
    localparam logic [2:0] WR_SB   = 3'b001;
    localparam logic [2:0] WR_SH   = 3'b010;
    localparam logic [2:0] WR_NONE = 3'b011;

    localparam logic [2:0] RD_LB  = 3'b000;
    localparam logic [2:0] RD_LH  = 3'b001;
    localparam logic [2:0] RD_LW  = 3'b010;
    localparam logic [2:0] RD_LBU = 3'b100;
    localparam logic [2:0] RD_LHU = 3'b101;

    localparam logic [1:0] OWNER_C  = 2'd0;
    localparam logic [1:0] OWNER_E  = 2'd1;
    localparam logic [1:0] NO_OWNER = 2'd2;

endpackage

// File: rtl/dmem_arb_resp.sv
// ----------------------------------------------------------------------------
// dmem_arb_resp
// Per-requester response stage: captures the memory read data on the cycle
// the requester is granted and raises rvalid for exactly one cycle after.
//   clk, rst_n  clock, asynchronous active-low reset
//   gnt_i       this requester won the memory this cycle
//   rdata_i     combinational memory read data
//   rvalid_o    one-cycle response pulse
//   rdata_o     registered read data (holds between grants)
// ----------------------------------------------------------------------------
module dmem_arb_resp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gnt_i,
    input  logic [WIDTH-1:0] rdata_i,
    output logic             rvalid_o,
    output logic [WIDTH-1:0] rdata_o
);

    logic             rvalid_q;
    logic [WIDTH-1:0] rdata_q;

    // Data only loads on a grant so the value of the last response stays
    // visible until this requester is served again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt_i;
            if (gnt_i) begin
                rdata_q <= rdata_i;
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory between the core (port C, fixed priority)
// and an external loader/debug port (port E). E is protected from starvation
// by a wait counter and can lock the memory for multi-beat bursts.
//   clk, rst_n                 clock, asynchronous active-low reset
//   c_* / e_*                  requester ports: req, addr, wdata, wr_ctrl,
//                              rd_ctrl in; gnt, rvalid, rdata out
//   c_stall                    core request refused this cycle
//   e_lock                     E keeps ownership after being granted
//   m_addr, m_wdata,
//   m_wr_ctrl, m_rd_ctrl       memory controls of the winning requester
//   m_rdata                    combinational memory read data
// Optional build macro DMEM_ARB_PERF_EN adds perf_clr (in) and saturating
// counters perf_c_stall_cnt / perf_e_wait_cnt (out).
// ----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WIDTH    = DATA_W,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             c_req,
    input  logic [WIDTH-1:0] c_addr,
    input  logic [WIDTH-1:0] c_wdata,
    input  logic [2:0]       c_wr_ctrl,
    input  logic [2:0]       c_rd_ctrl,
    output logic             c_gnt,
    output logic             c_stall,
    output logic             c_rvalid,
    output logic [WIDTH-1:0] c_rdata,
    input  logic             e_req,
    input  logic [WIDTH-1:0] e_addr,
    input  logic [WIDTH-1:0] e_wdata,
    input  logic [2:0]       e_wr_ctrl,
    input  logic [2:0]       e_rd_ctrl,
    input  logic             e_lock,
    output logic             e_gnt,
    output logic             e_rvalid,
    output logic [WIDTH-1:0] e_rdata,
    output logic [WIDTH-1:0] m_addr,
    output logic [WIDTH-1:0] m_wdata,
    output logic [2:0]       m_wr_ctrl,
    output logic [2:0]       m_rd_ctrl,
    input  logic [WIDTH-1:0] m_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] perf_c_stall_cnt,
    output logic [CNT_W-1:0] perf_e_wait_cnt
`endif
);

    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

    arb_state_e       state_q;
    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    logic [1:0]       owner;

    // Pick the single winner. Grants are forced low during reset so nothing
    // reaches the memory while rst_n is asserted.
    always_comb begin
        owner = NO_OWNER;
        if (!rst_n) begin
            owner = NO_OWNER;
        end else if (state_q == LOCK_E) begin
            if (e_req) owner = OWNER_E;
        end else if (e_req && (waitCnt_q == MAX_WAIT_C)) begin
            owner = OWNER_E;
        end else if (c_req) begin
            owner = OWNER_C;
        end else if (e_req) begin
            owner = OWNER_E;
        end
    end

    assign c_gnt   = (owner == OWNER_C);
    assign e_gnt   = (owner == OWNER_E);
    assign c_stall = c_req & ~c_gnt;

    // Only the winner's controls reach the memory; idle defaults to a
    // harmless word read of address 0 with writes disabled.
    always_comb begin
        m_addr    = '0;
        m_wdata   = '0;
        m_wr_ctrl = WR_NONE;
        m_rd_ctrl = RD_LW;
        if (owner == OWNER_C) begin
            m_addr    = c_addr;
            m_wdata   = c_wdata;
            m_wr_ctrl = c_wr_ctrl;
            m_rd_ctrl = c_rd_ctrl;
        end else if (owner == OWNER_E) begin
            m_addr    = e_addr;
            m_wdata   = e_wdata;
            m_wr_ctrl = e_wr_ctrl;
            m_rd_ctrl = e_rd_ctrl;
        end
    end

    // Starvation counter: counts refused E cycles up to MAX_WAIT, and resets
    // as soon as E is served or withdraws its request.
    always_comb begin
        waitCnt_d = '0;
        if (e_req && !e_gnt) begin
            waitCnt_d = (waitCnt_q == MAX_WAIT_C) ? waitCnt_q : waitCnt_q + 1'b1;
        end
    end

    // Lock FSM: the cycle in which e_lock drops still arbitrates as LOCK_E,
    // the release only takes effect on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB;
            waitCnt_q <= '0;
        end else begin
            waitCnt_q <= waitCnt_d;
            case (state_q)
                ARB:     if (e_gnt && e_lock) state_q <= LOCK_E;
                LOCK_E:  if (!e_lock)         state_q <= ARB;
                default: state_q <= ARB;
            endcase
        end
    end

    dmem_arb_resp #(.WIDTH(WIDTH)) u_resp_c (
        .clk      (clk),
        .rst_n    (rst_n),
        .gnt_i    (c_gnt),
        .rdata_i  (m_rdata),
        .rvalid_o (c_rvalid),
        .rdata_o  (c_rdata)
    );

    dmem_arb_resp #(.WIDTH(WIDTH)) u_resp_e (
        .clk      (clk),
        .rst_n    (rst_n),
        .gnt_i    (e_gnt),
        .rdata_i  (m_rdata),
        .rvalid_o (e_rvalid),
        .rdata_o  (e_rdata)
    );

`ifdef DMEM_ARB_PERF_EN
    logic [CNT_W-1:0] perfCStall_q;
    logic [CNT_W-1:0] perfEWait_q;

    // Saturating performance counters with a synchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perfCStall_q <= '0;
            perfEWait_q  <= '0;
        end else if (perf_clr) begin
            perfCStall_q <= '0;
            perfEWait_q  <= '0;
        end else begin
            if (c_stall && (perfCStall_q != '1)) perfCStall_q <= perfCStall_q + 1'b1;
            if (e_req && !e_gnt && (perfEWait_q != '1)) perfEWait_q <= perfEWait_q + 1'b1;
        end
    end

    assign perf_c_stall_cnt = perfCStall_q;
    assign perf_e_wait_cnt  = perfEWait_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a small behavioural word memory.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;
    localparam int W = 32;

    logic          clk;
    logic          rst_n;
    logic          c_req, e_req, e_lock;
    logic [W-1:0]  c_addr, c_wdata, e_addr, e_wdata;
    logic [2:0]    c_wr_ctrl, c_rd_ctrl, e_wr_ctrl, e_rd_ctrl;
    logic          c_gnt, c_stall, c_rvalid, e_gnt, e_rvalid;
    logic [W-1:0]  c_rdata, e_rdata;
    logic [W-1:0]  m_addr, m_wdata, m_rdata;
    logic [2:0]    m_wr_ctrl, m_rd_ctrl;
`ifdef DMEM_ARB_PERF_EN
    logic          perf_clr;
    logic [3:0]    perf_c_stall_cnt, perf_e_wait_cnt;
`endif

    int checks = 0;
    int failures = 0;

    logic [W-1:0] mem [0:63];

    dmem_arbiter #(.WIDTH(W), .MAX_WAIT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_wr_ctrl(c_wr_ctrl), .c_rd_ctrl(c_rd_ctrl),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .e_req(e_req), .e_addr(e_addr), .e_wdata(e_wdata),
        .e_wr_ctrl(e_wr_ctrl), .e_rd_ctrl(e_rd_ctrl), .e_lock(e_lock),
        .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wr_ctrl(m_wr_ctrl),
        .m_rd_ctrl(m_rd_ctrl), .m_rdata(m_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_clr(perf_clr), .perf_c_stall_cnt(perf_c_stall_cnt),
        .perf_e_wait_cnt(perf_e_wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: combinational word read, byte-lane writes on clock.
    assign m_rdata = mem[m_addr[7:2]];
    always @(posedge clk) begin
        case (m_wr_ctrl)
            3'b000: mem[m_addr[7:2]] <= m_wdata;
            3'b001: mem[m_addr[7:2]][8*m_addr[1:0] +: 8] <= m_wdata[7:0];
            3'b010: mem[m_addr[7:2]][16*m_addr[1] +: 16] <= m_wdata[15:0];
            default: ;
        endcase
    end

    task automatic setC(input logic req, input logic [W-1:0] addr,
                        input logic [W-1:0] wdata, input logic [2:0] wr,
                        input logic [2:0] rd);
        c_req = req; c_addr = addr; c_wdata = wdata; c_wr_ctrl = wr; c_rd_ctrl = rd;
    endtask

    task automatic setE(input logic req, input logic [W-1:0] addr,
                        input logic [W-1:0] wdata, input logic [2:0] wr,
                        input logic [2:0] rd, input logic lock);
        e_req = req; e_addr = addr; e_wdata = wdata; e_wr_ctrl = wr;
        e_rd_ctrl = rd; e_lock = lock;
    endtask

    task automatic idle();
        setC(1'b0, '0, '0, 3'b011, 3'b010);
        setE(1'b0, '0, '0, 3'b011, 3'b010, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        setC(1'b1, 32'h10, '0, 3'b000, 3'b010);
        setE(1'b1, 32'h14, '0, 3'b000, 3'b010, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (c_gnt !== 1'b0 || e_gnt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_grants: c_gnt=%b e_gnt=%b expected 0 0", c_gnt, e_gnt);
        end
        checks++;
        if (c_rvalid !== 1'b0 || e_rvalid !== 1'b0 || c_rdata !== '0 || e_rdata !== '0) begin
            failures++;
            $display("[TB] FAIL reset_resp: c_rvalid=%b e_rvalid=%b c_rdata=%h e_rdata=%h expected all 0",
                     c_rvalid, e_rvalid, c_rdata, e_rdata);
        end
        checks++;
        if (m_wr_ctrl !== 3'b011) begin
            failures++;
            $display("[TB] FAIL reset_mwr: m_wr_ctrl=%b expected 011", m_wr_ctrl);
        end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        setC(1'b1, 32'h10, '0, 3'b011, 3'b010);
        #1;
        checks++;
        if (c_gnt !== 1'b1 || e_gnt !== 1'b0 || c_stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_gnt: c_gnt=%b e_gnt=%b c_stall=%b expected 1 0 0", c_gnt, e_gnt, c_stall);
        end
        checks++;
        if (m_wr_ctrl !== 3'b011 || m_addr !== 32'h10 || m_rd_ctrl !== 3'b010) begin
            failures++;
            $display("[TB] FAIL read_mctl: m_wr=%b m_addr=%h m_rd=%b expected 011 10 010",
                     m_wr_ctrl, m_addr, m_rd_ctrl);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (c_rvalid !== 1'b1 || c_rdata !== 32'hDEADBEEF || e_rvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_resp: c_rvalid=%b c_rdata=%h e_rvalid=%b expected 1 deadbeef 0",
                     c_rvalid, c_rdata, e_rvalid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (c_rvalid !== 1'b0 || c_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL read_pulse: c_rvalid=%b c_rdata=%h expected 0 deadbeef", c_rvalid, c_rdata);
        end
    endtask

    task automatic test_starvation();
        logic expE;
        @(negedge clk);
        setC(1'b1, 32'h10, '0, 3'b011, 3'b010);
        setE(1'b1, 32'h14, '0, 3'b011, 3'b010, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            expE = (k == 5);
            checks++;
            if (c_gnt !== !expE || e_gnt !== expE || c_stall !== expE) begin
                failures++;
                $display("[TB] FAIL starve_cycle%0d: c_gnt=%b e_gnt=%b c_stall=%b expected %b %b %b",
                         k, c_gnt, e_gnt, c_stall, !expE, expE, expE);
            end
            if (k > 1) begin
                checks++;
                if (e_rvalid !== (k == 6) || c_rvalid !== (k != 6)) begin
                    failures++;
                    $display("[TB] FAIL starve_rvalid%0d: c_rvalid=%b e_rvalid=%b expected %b %b",
                             k, c_rvalid, e_rvalid, (k != 6), (k == 6));
                end
            end
        end
        checks++;
        if (e_rdata !== 32'hCAFEF00D || c_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL starve_rdata: e_rdata=%h c_rdata=%h expected cafef00d deadbeef",
                     e_rdata, c_rdata);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_lock_burst();
        @(negedge clk);
        setE(1'b1, 32'h20, 32'h12345678, 3'b000, 3'b010, 1'b1);
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
                @(negedge clk);
                setC(1'b1, 32'h10, '0, 3'b011, 3'b010);
                setE(1'b1, 32'h20 + 4 * b, 32'h12345678 + b, 3'b000, 3'b010, b != 3);
            end
            #1;
            checks++;
            if (e_gnt !== 1'b1 || c_gnt !== 1'b0 || m_wr_ctrl !== 3'b000 || m_addr !== 32'h20 + 4 * b) begin
                failures++;
                $display("[TB] FAIL lock_beat%0d: e_gnt=%b c_gnt=%b m_wr=%b m_addr=%h expected 1 0 000 %h",
                         b, e_gnt, c_gnt, m_wr_ctrl, m_addr, 32'h20 + 4 * b);
            end
        end
        @(negedge clk);
        setE(1'b0, '0, '0, 3'b011, 3'b010, 1'b0);
        setC(1'b1, 32'h20, '0, 3'b011, 3'b010);
        #1;
        checks++;
        if (c_gnt !== 1'b1) begin
            failures++;
            $display("[TB] FAIL lock_release: c_gnt=%b expected 1", c_gnt);
        end
        @(negedge clk);
        setC(1'b1, 32'h2C, '0, 3'b011, 3'b010);
        #1;
        checks++;
        if (c_rvalid !== 1'b1 || c_rdata !== 32'h12345678) begin
            failures++;
            $display("[TB] FAIL lock_readback: c_rvalid=%b c_rdata=%h expected 1 12345678", c_rvalid, c_rdata);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (c_rdata !== 32'h1234567B) begin
            failures++;
            $display("[TB] FAIL lock_dropbeat: c_rdata=%h expected 1234567b", c_rdata);
        end
    endtask

    task automatic test_idle();
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (c_gnt !== 1'b0 || e_gnt !== 1'b0 || m_wr_ctrl !== 3'b011 || m_rd_ctrl !== 3'b010 || m_addr !== '0) begin
            failures++;
            $display("[TB] FAIL idle_mctl: c_gnt=%b e_gnt=%b m_wr=%b m_rd=%b m_addr=%h expected 0 0 011 010 0",
                     c_gnt, e_gnt, m_wr_ctrl, m_rd_ctrl, m_addr);
        end
        @(negedge clk);
        setC(1'b1, 32'h20, '0, 3'b011, 3'b010);
        #1;
        checks++;
        if (c_rvalid !== 1'b0 || e_rvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_rvalid: c_rvalid=%b e_rvalid=%b expected 0 0", c_rvalid, e_rvalid);
        end
        @(negedge clk);
        setC(1'b1, 32'h00, '0, 3'b011, 3'b010);
        #1;
        checks++;
        if (c_rdata !== 32'h12345678) begin
            failures++;
            $display("[TB] FAIL idle_readback20: c_rdata=%h expected 12345678", c_rdata);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (c_rdata !== 32'h0BADF00D) begin
            failures++;
            $display("[TB] FAIL idle_readback00: c_rdata=%h expected 0badf00d", c_rdata);
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        setE(1'b1, 32'h14, '0, 3'b011, 3'b010, 1'b1);
        #1;
        checks++;
        if (e_gnt !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstburst_first: e_gnt=%b expected 1", e_gnt);
        end
        @(negedge clk);
        setC(1'b1, 32'h10, '0, 3'b011, 3'b010);
        #1;
        checks++;
        if (e_gnt !== 1'b1 || c_gnt !== 1'b0 || e_rvalid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rstburst_locked: e_gnt=%b c_gnt=%b e_rvalid=%b expected 1 0 1",
                     e_gnt, c_gnt, e_rvalid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (e_gnt !== 1'b0 || c_gnt !== 1'b0 || e_rvalid !== 1'b0 || c_rvalid !== 1'b0 || e_rdata !== '0) begin
            failures++;
            $display("[TB] FAIL rstburst_drop: e_gnt=%b c_gnt=%b e_rvalid=%b c_rvalid=%b e_rdata=%h expected 0 0 0 0 0",
                     e_gnt, c_gnt, e_rvalid, c_rvalid, e_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (c_gnt !== 1'b1 || e_gnt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rstburst_after: c_gnt=%b e_gnt=%b expected 1 0", c_gnt, e_gnt);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (c_rvalid !== 1'b1 || e_rvalid !== 1'b0 || c_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL rstburst_resp: c_rvalid=%b e_rvalid=%b c_rdata=%h expected 1 0 deadbeef",
                     c_rvalid, e_rvalid, c_rdata);
        end
    endtask

`ifdef DMEM_ARB_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        idle();
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        setC(1'b1, 32'h10, '0, 3'b011, 3'b010);
        setE(1'b1, 32'h14, '0, 3'b011, 3'b010, 1'b0);
        repeat (10) @(negedge clk);
        idle();
        #1;
        checks++;
        if (perf_c_stall_cnt !== 4'd2 || perf_e_wait_cnt !== 4'd8) begin
            failures++;
            $display("[TB] FAIL perf_count: c_stall_cnt=%0d e_wait_cnt=%0d expected 2 8",
                     perf_c_stall_cnt, perf_e_wait_cnt);
        end
        @(negedge clk);
        perf_clr = 1'b1;
        @(negedge clk);
        perf_clr = 1'b0;
        #1;
        checks++;
        if (perf_c_stall_cnt !== 4'd0 || perf_e_wait_cnt !== 4'd0) begin
            failures++;
            $display("[TB] FAIL perf_clr: c_stall_cnt=%0d e_wait_cnt=%0d expected 0 0",
                     perf_c_stall_cnt, perf_e_wait_cnt);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0]    = 32'h0BADF00D;
        mem[4]    = 32'hDEADBEEF;
        mem[5]    = 32'hCAFEF00D;
`ifdef DMEM_ARB_PERF_EN
        perf_clr = 1'b0;
`endif
        idle();
        test_reset();
        test_single_read();
        test_starvation();
        test_lock_burst();
        test_idle();
        test_reset_mid_burst();
`ifdef DMEM_ARB_PERF_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
